// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder: one byte per handshake, encoded MSB first,
// one bit per clock, with encoder memory carried across bytes until refresh.
module conv_encoder #(
    parameter int           DATA_W = 8,
    parameter logic [2:0]   G0     = 3'b111,
    parameter logic [2:0]   G1     = 3'b101
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   data_out,
    output logic                  busy
);

    // state    | meaning
    // IDLE     | waiting for a byte, in_ready high unless refresh
    // SHIFT    | encoding one bit per cycle, then one cycle to publish
    // HOLD     | codeword valid on data_out, waiting for out_ready
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] dout_q, dout_d;
    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic                u, g0, g1;

    assign u  = shreg_q[DATA_W-1];
    assign g0 = ^({u, s1_q, s2_q} & G0);
    assign g1 = ^({u, s1_q, s2_q} & G1);

    assign in_ready  = rst && (state_q == ST_IDLE) && !refresh;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign data_out  = dout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        if (refresh) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            s1_d    = 1'b0;
            s2_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg_d = data_in;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The accumulator is fully overwritten by DATA_W pairs, so it never needs clearing.
                    if (cnt_q == CNT_LAST) begin
                        dout_d  = acc_q;
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        acc_d   = {acc_q[2*DATA_W-3:0], g0, g1};
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                        s2_d    = s1_q;
                        s1_d    = u;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed scenarios plus random bytes
// compared against a bit-level arithmetic model of the K=3 code.
module tb_conv_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        refresh;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;
    int m1 = 0;
    int m2 = 0;

    conv_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .refresh   (refresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Generators as octal integers: 7 -> {u,s1,s2} all tapped, 5 -> u and s2.
    task automatic model_encode(input logic [7:0] b, output logic [15:0] cw);
        int gm0, gm1, u, p0, p1;
        int word;
        gm0  = 7;
        gm1  = 5;
        word = 0;
        for (int i = 0; i < 8; i++) begin
            u  = (int'(b) >> (7 - i)) & 1;
            p0 = (((gm0 >> 2) & 1) * u + ((gm0 >> 1) & 1) * m1 + (gm0 & 1) * m2) % 2;
            p1 = (((gm1 >> 2) & 1) * u + ((gm1 >> 1) & 1) * m1 + (gm1 & 1) * m2) % 2;
            word = word + (p0 * 2 + p1) * (1 << (14 - 2 * i));
            m2 = m1;
            m1 = u;
        end
        cw = word[15:0];
    endtask

    task automatic model_clear();
        m1 = 0;
        m2 = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic [15:0] exp, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1;
        data_in  = b;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 9);
        check({tag, "_data"}, data_out, exp);
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_pulse"}, out_valid, 0);
            check({tag, "_ready_back"}, in_ready, 1);
        end
    endtask

    initial begin
        logic [15:0] e;
        int seen;
        rst       = 1'b0;
        refresh   = 1'b0;
        in_valid  = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        model_encode(8'h00, e); send(8'h00, 16'h0000, "zero");
        model_encode(8'hFF, e); send(8'hFF, 16'hDAAA, "ones");
        model_encode(8'h00, e); send(8'h00, 16'h7000, "carry");

        model_encode(8'hFF, e); send(8'hFF, 16'hDAAA, "ones2");
        refresh  = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'h55;
        #1;
        check("refresh_blocks_ready", in_ready, 0);
        @(negedge clk);
        check("refresh_no_accept", busy, 0);
        refresh  = 1'b0;
        in_valid = 1'b0;
        model_clear();
        model_encode(8'h00, e); send(8'h00, 16'h0000, "after_refresh");
        model_encode(8'h80, e); send(8'h80, 16'hEC00, "impulse");

        out_ready = 1'b0;
        model_encode(8'h80, e); send(8'h80, 16'hEC00, "bp");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || data_out !== 16'hEC00 || in_ready) seen++;
        end
        check("bp_hold_stable", seen, 0);
        check("bp_data", data_out, 16'hEC00);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        check("bp_data_kept", data_out, 16'hEC00);

        in_valid = 1'b1;
        data_in  = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_never_valid", seen, 0);
        model_clear();
        model_encode(8'h80, e); send(8'h80, 16'hEC00, "abort_then_impulse");

        for (int k = 0; k < 30; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                refresh = 1'b1;
                @(negedge clk);
                refresh = 1'b0;
                model_clear();
            end
            model_encode(b, e);
            send(b, e, "rand");
        end

        in_valid = 1'b1;
        data_in  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 0);
        check("arst_data", data_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        model_encode(8'hFF, e); send(8'hFF, 16'hDAAA, "post_arst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
